// File: rtl/ijtc_gshare.sv
// Indirect jump target cache: tagged, gshare-indexed (PC ^ GHR), one lookup
// per lane of a fetch group. The block also owns the global history register,
// shifting it speculatively and restoring it from checkpoints on repair.

// Per-lane lookup slice: forms the lane PC, hands its index to the table,
// compares the returned tag and registers the lane's prediction.
module ijtc_gshare_lane #(
  parameter int unsigned LANE  = 0,
  parameter int unsigned IDX_W = 7,
  parameter int unsigned GHR_W = 8,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             look_i,
  input  logic [31:0]      base_i,
  input  logic [IDX_W-1:0] hfold_i,
  input  logic [GHR_W-1:0] ghr_i,
  output logic [IDX_W-1:0] idx_o,
  input  logic             ent_vld_i,
  input  logic [TAG_W-1:0] ent_tag_i,
  input  logic [31:0]      ent_tgt_i,
  output logic             hit_o,
  output logic [GHR_W-1:0] ckpt_o,
  output logic [31:0]      dest_o
);
  logic [31:0]      pc;
  logic             hit_d, hit_q;
  logic [GHR_W-1:0] ckpt_q;
  logic [31:0]      dest_d, dest_q;

  assign pc     = base_i + 32'(LANE * 4);
  assign idx_o  = pc[IDX_W+1:2] ^ hfold_i;
  assign hit_d  = ent_vld_i && (ent_tag_i == pc[IDX_W+TAG_W+1:IDX_W+2]);
  // Miss falls back to PC+8.
  assign dest_d = hit_d ? ent_tgt_i : pc + 32'd8;

  // Lane outputs update only on a lookup and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= 1'b0;
      ckpt_q <= '0;
      dest_q <= '0;
    end else if (look_i) begin
      hit_q  <= hit_d;
      ckpt_q <= ghr_i;
      dest_q <= dest_d;
    end
  end

  assign hit_o  = hit_q;
  assign ckpt_o = ckpt_q;
  assign dest_o = dest_q;
endmodule

module ijtc_gshare #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IDX_W = 7,
  parameter int unsigned GHR_W = 8,
  parameter int unsigned TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst_index_ok,
  input  logic                   inst_req,
  input  logic [31:0]            PCR_VAddr_i,
  output logic [LANES-1:0]       IJTC_hit_p_o,
  output logic [LANES*GHR_W-1:0] IJTC_checkPoint_p_o,
  output logic [LANES*32-1:0]    IJTC_predDest_p_o,
  input  logic                   FU_dirValid_i,
  input  logic                   FU_dirTake_i,
  input  logic                   FU_repairValid_i,
  input  logic [GHR_W-1:0]       FU_repairCheckPoint_i,
  input  logic [31:0]            FU_erroVAddr_i,
  input  logic                   FU_correctTake_i,
  input  logic [31:0]            FU_correctDest_i,
  input  logic                   FU_isIndirect_i
);
  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic                             look;
  logic [GHR_W-1:0]                 ghr_d, ghr_q;
  logic [IDX_W-1:0]                 ghr_fold, rep_fold, wr_idx;
  logic                             wr_en;
  logic [ENTRIES-1:0]               vld_q;
  logic [TAG_W-1:0]                 tag_q [ENTRIES];
  logic [31:0]                      tgt_q [ENTRIES];

  logic [LANES-1:0][IDX_W-1:0]      lane_idx;
  logic [LANES-1:0]                 rd_vld;
  logic [LANES-1:0][TAG_W-1:0]      rd_tag;
  logic [LANES-1:0][31:0]           rd_tgt;
  logic [LANES-1:0]                 hit;
  logic [LANES-1:0][GHR_W-1:0]      ckpt;
  logic [LANES-1:0][31:0]           dest;
  logic                             unused_w;

  assign look  = inst_index_ok && inst_req;
  assign wr_en = FU_repairValid_i && FU_isIndirect_i;

  // History fold: truncate a long GHR, zero-extend a short one.
  if (GHR_W >= IDX_W) begin : g_fold_trunc
    assign ghr_fold = ghr_q[IDX_W-1:0];
    assign rep_fold = FU_repairCheckPoint_i[IDX_W-1:0];
  end else begin : g_fold_ext
    assign ghr_fold = {{(IDX_W-GHR_W){1'b0}}, ghr_q};
    assign rep_fold = {{(IDX_W-GHR_W){1'b0}}, FU_repairCheckPoint_i};
  end

  assign wr_idx = FU_erroVAddr_i[IDX_W+1:2] ^ rep_fold;

  // Repair restores from the checkpoint and beats a same-cycle direction shift.
  always_comb begin
    ghr_d = ghr_q;
    if (FU_repairValid_i)
      ghr_d = {FU_repairCheckPoint_i[GHR_W-2:0], FU_correctTake_i};
    else if (FU_dirValid_i)
      ghr_d = {ghr_q[GHR_W-2:0], FU_dirTake_i};
  end

  // GHR and entry valid bits; the only state that needs a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q <= '0;
      vld_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (wr_en) vld_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload; no reset so it can map onto RAM. Valid guards reads.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      tag_q[wr_idx] <= FU_erroVAddr_i[IDX_W+TAG_W+1:IDX_W+2];
      tgt_q[wr_idx] <= FU_correctDest_i;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Reads see pre-write contents: no write-to-read bypass.
    assign rd_vld[i] = vld_q[lane_idx[i]];
    assign rd_tag[i] = tag_q[lane_idx[i]];
    assign rd_tgt[i] = tgt_q[lane_idx[i]];

    ijtc_gshare_lane #(
      .LANE(i), .IDX_W(IDX_W), .GHR_W(GHR_W), .TAG_W(TAG_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .look_i    (look),
      .base_i    (PCR_VAddr_i),
      .hfold_i   (ghr_fold),
      .ghr_i     (ghr_q),
      .idx_o     (lane_idx[i]),
      .ent_vld_i (rd_vld[i]),
      .ent_tag_i (rd_tag[i]),
      .ent_tgt_i (rd_tgt[i]),
      .hit_o     (hit[i]),
      .ckpt_o    (ckpt[i]),
      .dest_o    (dest[i])
    );
  end

  assign IJTC_hit_p_o        = hit;
  assign IJTC_checkPoint_p_o = ckpt;
  assign IJTC_predDest_p_o   = dest;

  // Only a slice of the repair PC and checkpoint reaches the hash/tag.
  assign unused_w = ^{FU_erroVAddr_i, FU_repairCheckPoint_i};
endmodule
